// File: rtl/mem_access_unit.sv
// MEM-stage load/store responder: drives a single-outstanding valid/ready RAM port and stalls until done.
// Optional macro MEM_ALIGN_CHECK_EN rejects misaligned half/word accesses and adds o_addr_error.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_mem_read_flag,
    input  logic        i_mem_write_flag,
    input  logic        i_mem_sign_ext_flag,
    input  logic [3:0]  i_mem_sel,
    input  logic [31:0] i_mem_write_data,
    input  logic [31:0] i_mem_addr,
    input  logic        i_flush,
    output logic        o_ram_en,
    output logic [3:0]  o_ram_write_en,
    output logic [31:0] o_ram_addr,
    output logic [31:0] o_ram_write_data,
    input  logic        i_ram_ready,
    input  logic [31:0] i_ram_read_data,
    output logic        o_stall_req,
    output logic [31:0] o_load_data,
    output logic        o_load_valid,
`ifdef MEM_ALIGN_CHECK_EN
    output logic        o_addr_error,
`endif
    output logic        o_bus_error
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_e;
    typedef enum logic [1:0] {SZ_NONE, SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

    state_e           r_state, w_state_next;
    size_e            w_size, r_size;
    logic [1:0]       w_off, r_off;
    logic [3:0]       w_lanes, r_we;
    logic [31:0]      w_wdata, r_wdata, r_addr, r_load_data;
    logic [31:0]      w_shifted, w_load;
    logic             r_sign, r_is_read, r_flushed, r_load_valid, r_bus_error;
    logic [CNT_W-1:0] r_cnt;
    logic             w_req, w_start, w_timeout;

    always_comb begin : decode
        // NOTE: every combinational output gets a default first so no path infers a latch.
        w_size  = SZ_NONE;
        w_off   = 2'b00;
        w_lanes = 4'b0000;
        w_wdata = '0;
        case (i_mem_sel)
            4'b0001: begin
                w_size  = SZ_BYTE;
                w_off   = i_mem_addr[1:0];
                w_lanes = 4'b0001 << i_mem_addr[1:0];
                w_wdata = {4{i_mem_write_data[7:0]}};
            end
            4'b0011: begin
                w_size  = SZ_HALF;
                w_off   = {i_mem_addr[1], 1'b0};
                w_lanes = 4'b0011 << {i_mem_addr[1], 1'b0};
                w_wdata = {2{i_mem_write_data[15:0]}};
            end
            4'b1111: begin
                w_size  = SZ_WORD;
                w_lanes = 4'b1111;
                w_wdata = i_mem_write_data;
            end
            default: ;
        endcase
    end

    // Gating with reset keeps stall_req low while the unit is held in reset.
    assign w_req = i_rst_n & (i_mem_read_flag | i_mem_write_flag) & ~i_flush & (w_size != SZ_NONE);

`ifdef MEM_ALIGN_CHECK_EN
    logic w_misaligned;
    assign w_misaligned = ((w_size == SZ_HALF) & i_mem_addr[0]) |
                          ((w_size == SZ_WORD) & (i_mem_addr[1:0] != 2'b00));
    assign w_start      = w_req & ~w_misaligned;
    assign o_addr_error = (r_state == ST_IDLE) & w_req & w_misaligned;
`else
    assign w_start = w_req;
`endif

    assign w_timeout = ~i_ram_ready & (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin : fsm_next
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_start) w_state_next = ST_BUSY;
            ST_BUSY: if (i_ram_ready | w_timeout) w_state_next = ST_DONE;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign o_ram_en    = (r_state == ST_BUSY);
    assign o_stall_req = ((r_state == ST_IDLE) & w_start) | o_ram_en;

    assign w_shifted = i_ram_read_data >> {r_off, 3'b000};

    always_comb begin : load_align
        w_load = w_shifted;
        case (r_size)
            SZ_BYTE: w_load = {{24{r_sign & w_shifted[7]}}, w_shifted[7:0]};
            SZ_HALF: w_load = {{16{r_sign & w_shifted[15]}}, w_shifted[15:0]};
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin : state_reg
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_state_next;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin : datapath
        if (!i_rst_n) begin
            r_addr       <= '0;
            r_we         <= '0;
            r_wdata      <= '0;
            r_off        <= '0;
            r_size       <= SZ_NONE;
            r_sign       <= 1'b0;
            r_is_read    <= 1'b0;
            r_flushed    <= 1'b0;
            r_cnt        <= '0;
            r_load_data  <= '0;
            r_load_valid <= 1'b0;
            r_bus_error  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_load_valid <= 1'b0;
            r_bus_error  <= 1'b0;
            case (r_state)
                ST_IDLE: if (w_start) begin
                    r_addr    <= {i_mem_addr[31:2], 2'b00};
                    r_we      <= i_mem_write_flag ? w_lanes : 4'b0000;
                    r_wdata   <= w_wdata;
                    r_off     <= w_off;
                    r_size    <= w_size;
                    r_sign    <= i_mem_sign_ext_flag;
                    r_is_read <= ~i_mem_write_flag;
                    r_flushed <= 1'b0;
                    r_cnt     <= '0;
                end
                ST_BUSY: begin
                    if (i_flush) r_flushed <= 1'b1;
                    if (i_ram_ready) begin
                        r_cnt <= '0;
                        if (r_is_read) begin
                            r_load_data  <= w_load;
                            r_load_valid <= ~(r_flushed | i_flush);
                        end
                    end else if (w_timeout) begin
                        r_cnt       <= '0;
                        r_bus_error <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_ram_write_en   = r_we;
    assign o_ram_addr       = r_addr;
    assign o_ram_write_data = r_wdata;
    assign o_load_data      = r_load_data;
    assign o_load_valid     = r_load_valid;
    assign o_bus_error      = r_bus_error;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: transaction-level model sets per-cycle expectations,
// one negedge compare process checks every output against them.
module tb_mem_access_unit;

    localparam int TIMEOUT = 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd, wr, sg, flush, ready;
    logic [3:0]  sel;
    logic [31:0] wd, addr, rdata;
    logic        ram_en, stall, lv, be;
    logic [3:0]  we;
    logic [31:0] ram_addr, ram_wdata, load_data;
`ifdef MEM_ALIGN_CHECK_EN
    logic        addr_error;
`endif

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .i_clk               (clk),
        .i_rst_n             (rst_n),
        .i_mem_read_flag     (rd),
        .i_mem_write_flag    (wr),
        .i_mem_sign_ext_flag (sg),
        .i_mem_sel           (sel),
        .i_mem_write_data    (wd),
        .i_mem_addr          (addr),
        .i_flush             (flush),
        .o_ram_en            (ram_en),
        .o_ram_write_en      (we),
        .o_ram_addr          (ram_addr),
        .o_ram_write_data    (ram_wdata),
        .i_ram_ready         (ready),
        .i_ram_read_data     (rdata),
        .o_stall_req         (stall),
        .o_load_data         (load_data),
        .o_load_valid        (lv),
`ifdef MEM_ALIGN_CHECK_EN
        .o_addr_error        (addr_error),
`endif
        .o_bus_error         (be)
    );

    int total = 0;
    int bad   = 0;

    logic        exp_stall, exp_ram_en, exp_lv, exp_be, exp_addr_error;
    logic [3:0]  exp_we;
    logic [31:0] exp_addr, exp_wdata, exp_load_data;
    bit          chk_on = 1'b0;

    int          run_len = 0, last_len = 0, stall_run = 0, last_stall_len = 0;
    logic [3:0]  cap_we;
    logic [31:0] cap_addr, cap_wdata;

    logic [3:0] sel_tab [9] = '{4'h1, 4'h3, 4'hF, 4'h1, 4'h3, 4'hF, 4'h0, 4'h2, 4'h7};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit valid_sel(input logic [3:0] s);
        return (s == 4'h1) || (s == 4'h3) || (s == 4'hF);
    endfunction

    function automatic int shift_of(input logic [3:0] s, input logic [31:0] a);
        if (s == 4'h1) return int'(a % 4) * 8;
        if (s == 4'h3) return int'(a & 32'd2) * 8;
        return 0;
    endfunction

    function automatic logic [3:0] lanes_of(input logic [3:0] s, input logic [31:0] a);
        if (s == 4'h1) return 4'(1 << (a % 4));
        if (s == 4'h3) return 4'(3 << (a & 32'd2));
        return 4'hF;
    endfunction

    function automatic logic [31:0] wdata_of(input logic [3:0] s, input logic [31:0] d);
        if (s == 4'h1) return (d & 32'hFF) * 32'h0101_0101;
        if (s == 4'h3) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] load_of(input logic [3:0] s, input logic [31:0] a,
                                            input logic [31:0] r, input bit sign);
        logic [31:0] v;
        v = r >> shift_of(s, a);
        if (s == 4'h1) begin
            v = v & 32'hFF;
            if (sign && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (s == 4'h3) begin
            v = v & 32'hFFFF;
            if (sign && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            check("stall_req", 32'(stall), 32'(exp_stall));
            check("ram_en", 32'(ram_en), 32'(exp_ram_en));
            if (exp_ram_en) begin
                check("ram_write_en", 32'(we), 32'(exp_we));
                check("ram_addr", ram_addr, exp_addr);
                check("ram_write_data", ram_wdata, exp_wdata);
            end
            check("load_valid", 32'(lv), 32'(exp_lv));
            check("bus_error", 32'(be), 32'(exp_be));
            check("load_data", load_data, exp_load_data);
`ifdef MEM_ALIGN_CHECK_EN
            check("addr_error", 32'(addr_error), 32'(exp_addr_error));
`endif
            if (ram_en) begin
                run_len++;
                cap_we    = we;
                cap_addr  = ram_addr;
                cap_wdata = ram_wdata;
            end else if (run_len != 0) begin
                last_len = run_len;
                run_len  = 0;
            end
            if (stall) stall_run++;
            else if (stall_run != 0) begin
                last_stall_len = stall_run;
                stall_run      = 0;
            end
        end
    end

    task automatic set_idle();
        rd = 1'b0; wr = 1'b0; flush = 1'b0; ready = 1'b0;
        exp_stall = 1'b0; exp_ram_en = 1'b0; exp_lv = 1'b0; exp_be = 1'b0; exp_addr_error = 1'b0;
    endtask

    // One instruction: start cycle, BUSY until ready (after t_delay waits) or timeout, DONE.
    task automatic do_txn(input bit t_rd, input bit t_wr, input bit t_sg, input logic [3:0] t_sel,
                          input logic [31:0] t_addr, input logic [31:0] t_wd, input logic [31:0] t_rdat,
                          input int t_delay, input int t_flush_at, input bit t_sflush);
        bit mis, req, start, is_read, flushed, timed_out;
        mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        mis = (t_sel == 4'h3 && t_addr[0]) || (t_sel == 4'hF && t_addr[1:0] != 2'b00);
`endif
        req     = (t_rd || t_wr) && !t_sflush && valid_sel(t_sel);
        start   = req && !mis;
        is_read = t_rd && !t_wr;
        rd = t_rd; wr = t_wr; sg = t_sg; sel = t_sel; addr = t_addr; wd = t_wd;
        flush = t_sflush; ready = 1'b0;
        exp_stall = start; exp_ram_en = 1'b0; exp_lv = 1'b0; exp_be = 1'b0;
        exp_addr_error = req && mis;
        step();
        exp_addr_error = 1'b0;
        if (!start) begin
            set_idle();
            return;
        end
        exp_we    = t_wr ? lanes_of(t_sel, t_addr) : 4'h0;
        exp_addr  = t_addr & 32'hFFFF_FFFC;
        exp_wdata = wdata_of(t_sel, t_wd);
        flushed   = 1'b0;
        timed_out = 1'b1;
        for (int k = 1; k <= TIMEOUT; k++) begin
            exp_ram_en = 1'b1;
            exp_stall  = 1'b1;
            flush = (k == t_flush_at);
            if (flush) flushed = 1'b1;
            ready = (k == t_delay + 1);
            rdata = ready ? t_rdat : $urandom;
            if (ready) begin
                timed_out = 1'b0;
                step();
                break;
            end
            step();
        end
        ready = 1'b0; flush = 1'b0;
        exp_ram_en = 1'b0; exp_stall = 1'b0;
        exp_be = timed_out;
        exp_lv = is_read && !timed_out && !flushed;
        if (is_read && !timed_out) exp_load_data = load_of(t_sel, t_addr, t_rdat, t_sg);
        step();
        set_idle();
    endtask

    initial begin
        rd = 1'b0; wr = 1'b0; sg = 1'b0; flush = 1'b0; ready = 1'b0;
        sel = 4'h0; wd = '0; addr = '0; rdata = '0;
        exp_we = '0; exp_addr = '0; exp_wdata = '0; exp_load_data = '0;
        set_idle();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("reset_ram_addr", ram_addr, 32'h0);
        check("reset_ram_wdata", ram_wdata, 32'h0);
        check("reset_ram_we", 32'(we), 32'h0);
        chk_on = 1'b1;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        do_txn(1, 0, 1, 4'h1, 32'h1003, 32'h0, 32'h8012_3456, 0, 0, 0);
        check("lb_value", load_data, 32'hFFFF_FF80);
        check("lb_busy_len", 32'(last_len), 32'd1);
        do_txn(1, 0, 0, 4'h3, 32'h1002, 32'h0, 32'hBEEF_1234, 0, 0, 0);
        check("lhu_value", load_data, 32'h0000_BEEF);
        do_txn(0, 1, 0, 4'h3, 32'h6, 32'h5678, 32'h0, 0, 0, 0);
        check("sh_we", 32'(cap_we), 32'(4'b1100));
        check("sh_wdata", cap_wdata, 32'h5678_5678);
        check("sh_addr", cap_addr, 32'h4);
        do_txn(0, 1, 0, 4'hF, 32'h10, 32'hCAFE_F00D, 32'h0, 3, 0, 0);
        check("sw_busy_len", 32'(last_len), 32'd4);
        check("sw_stall_len", 32'(last_stall_len), 32'd5);
        do_txn(1, 1, 0, 4'h1, 32'h21, 32'hA5, 32'h0, 1, 0, 0);
        check("rw_write_wins_we", 32'(cap_we), 32'(4'b0010));
        do_txn(1, 0, 0, 4'hF, 32'h40, 32'h0, 32'h0, TIMEOUT + 50, 0, 0);
        check("timeout_busy_len", 32'(last_len), 32'd256);
        check("timeout_load_kept", load_data, 32'h0000_BEEF);
        do_txn(1, 0, 0, 4'hF, 32'h80, 32'h0, 32'h1111_2222, 2, 1, 0);
        do_txn(1, 0, 0, 4'hF, 32'h84, 32'h0, 32'h3333_4444, 0, 0, 1);

        // Reset in the middle of a BUSY read with the request still presented.
        rd = 1'b1; wr = 1'b0; sel = 4'hF; addr = 32'h20; wd = 32'h0; ready = 1'b0; flush = 1'b0;
        exp_stall = 1'b1;
        step();
        exp_ram_en = 1'b1; exp_we = 4'h0; exp_addr = 32'h20; exp_wdata = 32'h0;
        step();
        #1;
        rst_n = 1'b0;
        exp_ram_en = 1'b0; exp_stall = 1'b0; exp_load_data = '0;
        #1;
        check("midrst_ram_en", 32'(ram_en), 32'h0);
        check("midrst_stall", 32'(stall), 32'h0);
        check("midrst_load_data", load_data, 32'h0);
        check("midrst_ram_addr", ram_addr, 32'h0);
        step();
        set_idle();
        step();
        rst_n = 1'b1;
        step();

`ifdef MEM_ALIGN_CHECK_EN
        do_txn(1, 0, 0, 4'hF, 32'h2, 32'h0, 32'h0, 0, 0, 0);
        check("misaligned_no_access", 32'(last_len), 32'd1);
`endif

        for (int n = 0; n < 200; n++) begin
            int d, fa, gap;
            bit r_rd, r_wr;
            d  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 12)) : int'($urandom_range(0, 3));
            fa = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, d + 1)) : 0;
            r_rd = 1'($urandom_range(0, 1));
            r_wr = ($urandom_range(0, 3) == 0) ? 1'b1 : !r_rd;
            do_txn(r_rd, r_wr, 1'($urandom_range(0, 1)), sel_tab[$urandom_range(0, 8)],
                   $urandom, $urandom, $urandom, d, fa, ($urandom_range(0, 14) == 0));
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                ready = 1'($urandom_range(0, 1));
                rdata = $urandom;
                step();
            end
            ready = 1'b0;
        end
        step();
        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        bad++;
        $display("FAIL watchdog: got still running want finished at %0t", $time);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
